// File: rtl/buf_ctrl_pkg.sv
// Shared command codes and read-sweep state encoding for the CFU buffer index controller.
package buf_ctrl_pkg;

    localparam logic [2:0] FUNCT_WRITE = 3'd2;
    localparam logic [2:0] FUNCT_CLEAR = 3'd4;
    localparam logic [2:0] FUNCT_SET_K = 3'd5;
    localparam logic [2:0] FUNCT_START = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/rd_sweep_fsm.sv
// Read-side sweep FSM: walks rd_idx over 0..K with downstream back-pressure.
// Multi-pass sweeps are available when BUF_IDX_CTRL_REPEAT_EN is defined.
module rd_sweep_fsm
    import buf_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             set_k,
    input  logic             start,
    input  logic [IDX_W-1:0] k_in,
`ifdef BUF_IDX_CTRL_REPEAT_EN
    input  logic [7:0]       rep_in,
`endif
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] K_MAX = IDX_W'(DEPTH - 1);

    sweep_state_e     state;
    logic [IDX_W-1:0] k_reg;
    logic [IDX_W-1:0] rd_idx_q;
    logic             last_pass;

`ifdef BUF_IDX_CTRL_REPEAT_EN
    logic [7:0] rep_reg;
    logic [7:0] pass_cnt;

    assign last_pass = (pass_cnt == rep_reg);
`else
    assign last_pass = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            k_reg    <= '0;
            rd_idx_q <= '0;
`ifdef BUF_IDX_CTRL_REPEAT_EN
            rep_reg  <= '0;
            pass_cnt <= '0;
`endif
        end else if (clear) begin
            state    <= IDLE;
            rd_idx_q <= '0;
`ifdef BUF_IDX_CTRL_REPEAT_EN
            rep_reg  <= '0;
            pass_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (set_k) begin
                        k_reg   <= (k_in > K_MAX) ? K_MAX : k_in;
`ifdef BUF_IDX_CTRL_REPEAT_EN
                        rep_reg <= rep_in;
`endif
                    end else if (start) begin
                        state    <= RUN;
                        rd_idx_q <= '0;
`ifdef BUF_IDX_CTRL_REPEAT_EN
                        pass_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    // rd_valid is implied by RUN, so rd_ready alone marks an accepted beat
                    if (rd_ready) begin
                        if (rd_idx_q == k_reg) begin
                            if (last_pass) begin
                                state <= DONE;
                            end else begin
                                rd_idx_q <= '0;
`ifdef BUF_IDX_CTRL_REPEAT_EN
                                pass_cnt <= pass_cnt + 8'd1;
`endif
                            end
                        end else begin
                            rd_idx_q <= rd_idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    rd_idx_q <= '0;
                end
                default: begin
                    state    <= IDLE;
                    rd_idx_q <= '0;
                end
            endcase
        end
    end

    assign rd_idx   = rd_idx_q;
    assign rd_valid = (state == RUN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: rtl/buf_idx_ctrl.sv
// CFU operand-buffer index controller: command decode, registered write path and read sweep.
// Optional multi-pass sweep enabled by defining BUF_IDX_CTRL_REPEAT_EN.
module buf_idx_ctrl
    import buf_ctrl_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [2:0]            funct,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic                  rd_ready,
    output logic [NCH-1:0]        wr_en,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [NCH*DATA_W-1:0] wr_data,
    output logic                  wr_full,
    output logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done
);

    // One extra bit so the pointer can sit at DEPTH even when DEPTH == 2**IDX_W
    localparam int unsigned      PTR_W    = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    logic             is_write;
    logic             is_clear;
    logic             is_set_k;
    logic             is_start;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;

    assign is_write   = cmd_valid && (funct == FUNCT_WRITE);
    assign is_clear   = cmd_valid && (funct == FUNCT_CLEAR);
    assign is_set_k   = cmd_valid && (funct == FUNCT_SET_K);
    assign is_start   = cmd_valid && (funct == FUNCT_START);
    assign wr_ptr_nxt = wr_ptr + PTR_W'(1);

    // wr_full is updated alongside wr_ptr so it always equals (wr_ptr == DEPTH)
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr  <= '0;
            wr_full <= 1'b0;
            wr_en   <= '0;
            wr_idx  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= '0;
            if (is_clear) begin
                wr_ptr  <= '0;
                wr_full <= 1'b0;
            end else if (is_write && !wr_full) begin
                wr_en   <= '1;
                wr_idx  <= wr_ptr[IDX_W-1:0];
                wr_data <= in_data;
                wr_ptr  <= wr_ptr_nxt;
                wr_full <= (wr_ptr_nxt == PTR_FULL);
            end
        end
    end

    rd_sweep_fsm #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_rd_sweep_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (is_clear),
        .set_k    (is_set_k),
        .start    (is_start),
        .k_in     (in_data[IDX_W-1:0]),
`ifdef BUF_IDX_CTRL_REPEAT_EN
        .rep_in   (in_data[IDX_W+7:IDX_W]),
`endif
        .rd_ready (rd_ready),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done)
    );

endmodule

// File: tb/tb_buf_idx_ctrl.sv
// Self-checking bench for buf_idx_ctrl: write path, fill limit, read sweeps, abort and clamp.
module tb_buf_idx_ctrl;

    localparam int NCH    = 2;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 16;
    localparam int DEPTH  = 1024;
    localparam int DEPTH4 = 4;
`ifdef BUF_IDX_CTRL_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    localparam logic [2:0] F_WRITE = 3'd2;
    localparam logic [2:0] F_CLEAR = 3'd4;
    localparam logic [2:0] F_SET_K = 3'd5;
    localparam logic [2:0] F_START = 3'd6;

    logic                  clk;
    logic                  rst_n;
    logic                  cmd_valid;
    logic [2:0]            funct;
    logic [NCH*DATA_W-1:0] in_data;
    logic                  rd_ready;

    logic [NCH-1:0]        wr_en,    wr_en_4;
    logic [IDX_W-1:0]      wr_idx,   wr_idx_4;
    logic [NCH*DATA_W-1:0] wr_data,  wr_data_4;
    logic                  wr_full,  wr_full_4;
    logic [IDX_W-1:0]      rd_idx,   rd_idx_4;
    logic                  rd_valid, rd_valid_4;
    logic                  busy,     busy_4;
    logic                  done,     done_4;

    int n_cmp = 0;
    int n_err = 0;

    buf_idx_ctrl #(.NCH(NCH), .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .funct(funct), .in_data(in_data),
        .rd_ready(rd_ready), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_full(wr_full), .rd_idx(rd_idx), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    buf_idx_ctrl #(.NCH(NCH), .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .funct(funct), .in_data(in_data),
        .rd_ready(rd_ready), .wr_en(wr_en_4), .wr_idx(wr_idx_4), .wr_data(wr_data_4),
        .wr_full(wr_full_4), .rd_idx(rd_idx_4), .rd_valid(rd_valid_4), .busy(busy_4), .done(done_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] f, input logic [NCH*DATA_W-1:0] d);
        cmd_valid = 1'b1;
        funct     = f;
        in_data   = d;
        tick();
        cmd_valid = 1'b0;
        funct     = 3'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        cmd(F_WRITE, {32'hdead_beef, 32'hcafe_f00d});
        cmd(F_START, '0);
        repeat (2) tick();
        n_cmp++;
        if ({wr_en, wr_idx, wr_data, wr_full} !== '0) begin
            n_err++;
            $display("FAIL reset_wr: got en=%b idx=%0d data=%h full=%b exp all 0", wr_en, wr_idx, wr_data, wr_full);
        end
        n_cmp++;
        if ({rd_idx, rd_valid, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_rd: got idx=%0d valid=%b busy=%b done=%b exp all 0", rd_idx, rd_valid, busy, done);
        end
        n_cmp++;
        if ({wr_en_4, wr_full_4, rd_valid_4, busy_4} !== '0) begin
            n_err++;
            $display("FAIL reset_d4: got en=%b full=%b valid=%b busy=%b exp 0", wr_en_4, wr_full_4, rd_valid_4, busy_4);
        end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int                    cnt = 0;
        logic [IDX_W-1:0]      e_idx = '0;
        logic [NCH*DATA_W-1:0] e_data = '0;
        logic [NCH*DATA_W-1:0] d;
        cmd(F_CLEAR, '0);
        for (int i = 0; i < 23; i++) begin
            if (i >= 3 && $urandom_range(0, 2) == 0) begin
                tick();
                n_cmp++;
                if (wr_en !== 2'b00 || wr_idx !== e_idx || wr_data !== e_data) begin
                    n_err++;
                    $display("FAIL write_idle: got en=%b idx=%0d data=%h exp en=00 idx=%0d data=%h", wr_en, wr_idx, wr_data, e_idx, e_data);
                end
            end else begin
                d = {$urandom(), $urandom()};
                if (i < 3) d[31:0] = 32'h11 * (i + 1);
                cmd(F_WRITE, d);
                e_idx  = IDX_W'(cnt);
                e_data = d;
                cnt++;
                n_cmp++;
                if (wr_en !== 2'b11 || wr_idx !== e_idx || wr_data !== e_data || wr_full !== 1'b0) begin
                    n_err++;
                    $display("FAIL write_beat: got en=%b idx=%0d data=%h full=%b exp en=11 idx=%0d data=%h full=0", wr_en, wr_idx, wr_data, wr_full, e_idx, e_data);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [NCH*DATA_W-1:0] d;
        logic [NCH*DATA_W-1:0] last = '0;
        cmd(F_CLEAR, '0);
        for (int i = 0; i < 5; i++) begin
            d = {$urandom(), $urandom()};
            cmd(F_WRITE, d);
            if (i < DEPTH4) begin
                last = d;
                n_cmp++;
                if (wr_en_4 !== 2'b11 || wr_idx_4 !== IDX_W'(i) || wr_data_4 !== d || wr_full_4 !== (i == DEPTH4 - 1)) begin
                    n_err++;
                    $display("FAIL full_fill: got en=%b idx=%0d full=%b exp en=11 idx=%0d full=%b", wr_en_4, wr_idx_4, wr_full_4, i, (i == DEPTH4 - 1));
                end
            end else begin
                n_cmp++;
                if (wr_en_4 !== 2'b00 || wr_idx_4 !== IDX_W'(DEPTH4 - 1) || wr_data_4 !== last || wr_full_4 !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_drop: got en=%b idx=%0d data=%h full=%b exp en=00 idx=%0d data=%h full=1", wr_en_4, wr_idx_4, wr_data_4, wr_full_4, DEPTH4 - 1, last);
                end
            end
        end
        cmd(F_CLEAR, '0);
        n_cmp++;
        if (wr_full_4 !== 1'b0 || wr_en_4 !== 2'b00) begin
            n_err++;
            $display("FAIL full_clear: got full=%b en=%b exp full=0 en=00", wr_full_4, wr_en_4);
        end
        d = {$urandom(), $urandom()};
        cmd(F_WRITE, d);
        n_cmp++;
        if (wr_en_4 !== 2'b11 || wr_idx_4 !== '0 || wr_data_4 !== d) begin
            n_err++;
            $display("FAIL full_rewrite: got en=%b idx=%0d exp en=11 idx=0", wr_en_4, wr_idx_4);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,1 then 1
    task automatic test_sweep(input int k_set, input int rep, input int mode, input bit poke_start);
        int                    q[$];
        int                    k_exp;
        int                    passes;
        int                    cyc = 0;
        bit                    r;
        bit                    bad = 1'b0;
        logic [NCH*DATA_W-1:0] d = '0;
        logic [4:0]            pat = 5'b11001;
        k_exp  = (k_set > DEPTH - 1) ? DEPTH - 1 : k_set;
        passes = REP_EN ? rep + 1 : 1;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i <= k_exp; i++) q.push_back(i);
        d[IDX_W-1:0]     = IDX_W'(k_set);
        d[IDX_W+7:IDX_W] = 8'(rep);
        d[63:32]         = $urandom();
        rd_ready = 1'b0;
        cmd(F_SET_K, d);
        cmd(F_START, {$urandom(), 32'h0});
        while (q.size() > 0 && cyc < 5000 && !bad) begin
            n_cmp++;
            if (rd_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                n_err++; bad = 1'b1;
                $display("FAIL sweep_run: got valid=%b busy=%b done=%b exp 1,1,0 at beat %0d", rd_valid, busy, done, cyc);
            end
            n_cmp++;
            if (rd_idx !== IDX_W'(q[0])) begin
                n_err++; bad = 1'b1;
                $display("FAIL sweep_idx: got %0d exp %0d at beat %0d", rd_idx, q[0], cyc);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc < 5) ? pat[cyc] : 1'b1;
            endcase
            if (poke_start && cyc == 1) begin
                cmd_valid = 1'b1;
                funct     = F_START;
            end
            rd_ready = r;
            tick();
            cmd_valid = 1'b0;
            funct     = 3'd0;
            if (r) void'(q.pop_front());
            cyc++;
        end
        rd_ready = 1'(mode != 0);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sweep_len: got %0d beats left unaccepted exp 0", q.size());
        end
        n_cmp++;
        if (rd_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_done: got valid=%b done=%b busy=%b exp 0,1,1", rd_valid, done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0 || rd_idx !== '0) begin
            n_err++;
            $display("FAIL sweep_idle: got done=%b busy=%b valid=%b idx=%0d exp 0,0,0,0", done, busy, rd_valid, rd_idx);
        end
        rd_ready = 1'b0;
        cmd(F_CLEAR, '0);
    endtask

    task automatic test_abort();
        logic [NCH*DATA_W-1:0] d;
        for (int j = 0; j < 2; j++) begin
            d = '0;
            d[IDX_W-1:0] = IDX_W'(3);
            cmd(F_WRITE, {$urandom(), $urandom() | 32'h1});
            cmd(F_SET_K, d);
            cmd(F_START, '0);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            n_cmp++;
            if (rd_idx !== IDX_W'(1) || rd_valid !== 1'b1) begin
                n_err++;
                $display("FAIL abort_pre: got idx=%0d valid=%b exp idx=1 valid=1", rd_idx, rd_valid);
            end
            if (j == 0) begin
                rst_n = 1'b1;
                tick();
                rst_n = 1'b0;
                n_cmp++;
                if ({wr_en, wr_idx, wr_data, wr_full} !== '0) begin
                    n_err++;
                    $display("FAIL abort_rst_wr: got en=%b idx=%0d data=%h full=%b exp all 0", wr_en, wr_idx, wr_data, wr_full);
                end
            end else begin
                cmd(F_CLEAR, '0);
            end
            n_cmp++;
            if ({rd_idx, rd_valid, busy, done} !== '0) begin
                n_err++;
                $display("FAIL abort_rd_%0d: got idx=%0d valid=%b busy=%b done=%b exp all 0", j, rd_idx, rd_valid, busy, done);
            end
            rd_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                tick();
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_quiet_%0d: got done=%b busy=%b exp 0,0", j, done, busy);
                end
            end
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        funct     = 3'd0;
        in_data   = '0;
        rd_ready  = 1'b0;
        test_reset();
        test_write();
        test_full();
        test_sweep(3, 0, 0, 1'b0);
        test_sweep(2, 0, 2, 1'b1);
        test_sweep(0, 0, 1, 1'b0);
        test_abort();
        test_sweep(1, 2, 0, 1'b0);
        test_sweep(5000, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            test_sweep(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/buf_idx_ctrl.md
Name: buf_idx_ctrl

Overview:
- Parametrised multi-channel write/read index controller for the CFU operand buffers.
- Write side: accepts CFU write commands, registers data and a shared write index for NCH buffers, and tracks the fill level.
- Read side: a start/done sweep FSM walks read indices 0..K into the systolic array, with downstream back-pressure.

Parameters:
- NCH, 2, number of buffer channels (A, B, ...).
- DATA_W, 32, data width per channel.
- IDX_W, 16, index width.
- DEPTH, 1024, entries per buffer; must satisfy DEPTH <= 2**IDX_W.

Ports:
- clk in 1: clock.
- rst_n in 1: reset, synchronous, active-high (1 = reset).
- cmd_valid in 1: CFU command strobe.
- funct in 3: command code; 2=WRITE, 4=CLEAR, 5=SET_K, 6=START; all other codes ignored.
- in_data in NCH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- rd_ready in 1: downstream accepts the current rd_idx.
- wr_en out NCH: per-channel buffer write enable.
- wr_idx out IDX_W: write address, shared by all channels.
- wr_data out NCH*DATA_W: registered write data.
- wr_full out 1: write pointer has reached DEPTH.
- rd_idx out IDX_W: read address.
- rd_valid out 1: rd_idx is valid this cycle.
- busy out 1: FSM is not IDLE.
- done out 1: one-cycle pulse at sweep end.

Behaviour:
- Reset (any cycle, including mid-sweep): all outputs 0, wr_ptr=0, k_reg=0, FSM=IDLE.
- Commands act only when cmd_valid=1.
- WRITE, latency 1:
  - Next cycle: wr_en=all ones, wr_idx=wr_ptr, wr_data=in_data; wr_ptr increments.
  - If wr_ptr==DEPTH, the write is dropped: wr_en=0, wr_idx and wr_data hold, wr_ptr holds.
  - wr_full = (wr_ptr==DEPTH), registered.
  - wr_en is 0 in every cycle without an accepted WRITE; wr_idx and wr_data hold.
- CLEAR: next cycle wr_ptr=0, wr_full=0, rd_idx=0, FSM=IDLE, rd_valid=0. Aborts any sweep; no done pulse.
- SET_K:
  - Legal only in IDLE; ignored otherwise.
  - k_reg = in_data[IDX_W-1:0] from channel 0, clamped to DEPTH-1.
  - A sweep covers indices 0..K inclusive (K+1 entries); K=0 gives one entry.
- START:
  - In IDLE: FSM goes to RUN next cycle with rd_idx=0, rd_valid=1.
  - Ignored in RUN or DONE.
- FSM states IDLE, RUN, DONE:
  - RUN: rd_idx increments only on cycles with rd_valid & rd_ready. If rd_ready=0, rd_idx holds and rd_valid stays 1.
  - RUN -> DONE: on an accepted beat with rd_idx==k_reg. Next cycle rd_valid=0 and done=1.
  - DONE -> IDLE: unconditional; rd_idx resets to 0.
- busy=1 in RUN and DONE.
- WRITE is accepted in any FSM state. No read/write address-conflict checking.
- Index arithmetic is unsigned and modulo 2**IDX_W; the clamp guarantees rd_idx never exceeds DEPTH-1.

Optional Feature:
- Macro: BUF_IDX_CTRL_REPEAT_EN.
- Defined:
  - SET_K also loads rep_reg = channel-0 bits [IDX_W+7:IDX_W].
  - The sweep runs rep_reg+1 passes; rd_idx wraps K -> 0 between passes with no bubble.
  - done pulses only after the final pass.
  - CLEAR zeroes rep_reg.
- Undefined: single pass; bits [IDX_W+7:IDX_W] are ignored.

Decomposition:
- Package buf_ctrl_pkg holds:
  - funct code localparams: FUNCT_WRITE=2, FUNCT_CLEAR=4, FUNCT_SET_K=5, FUNCT_START=6.
  - FSM state enum (IDLE, RUN, DONE).
- Sub-module rd_sweep_fsm contains:
  - the FSM, k_reg, rd_idx and done logic;
  - the optional repeat counter.
- The top level keeps the write path and command decode.

Test Plan:
1. Reset, then 3 WRITEs with ch0 data 0x11/0x22/0x33 -> wr_en=2'b11 on cycles 1..3 after each command, wr_idx=0,1,2, wr_data[31:0] matches.
2. DEPTH=4; 5 WRITEs -> 5th dropped (wr_en=0), wr_full=1 after the 4th; CLEAR -> wr_full=0; next WRITE lands at wr_idx=0.
3. SET_K=3, START, rd_ready=1 -> rd_idx 0,1,2,3 on consecutive cycles, then done=1 for exactly one cycle, busy falls the cycle after.
4. SET_K=2, START, rd_ready toggled 1,0,0,1,1 -> rd_idx holds during stalls; done only after index 2 is accepted; START issued mid-RUN has no effect.
5. Mid-sweep at rd_idx=1: assert rst_n=1 one cycle -> all outputs 0, FSM IDLE; repeat the scenario with CLEAR -> same outcome, no done pulse.
6. REPEAT_EN: K=1, rep=2 -> rd_idx 0,1,0,1,0,1, then a single done pulse; SET_K=5000 with DEPTH=1024 -> k_reg=1023.
